// File: rtl/alu_rs_pkg.sv
// Types and constants shared by the ALU reservation station and its bench.
`include "define.vh"

package alu_rs_pkg;

    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;
    localparam int unsigned ROB_WIDTH  = `ROB_WIDTH;
    localparam int unsigned OP_WIDTH   = `OP_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = `OP_ADD;
    localparam logic [OP_WIDTH-1:0] OP_ADDI = `OP_ADDI;

    typedef struct packed {
        logic                  busy;
        logic [OP_WIDTH-1:0]   opcode;
        logic [DATA_WIDTH-1:0] vj;
        logic [DATA_WIDTH-1:0] vk;
        logic [ROB_WIDTH-1:0]  qj;
        logic [ROB_WIDTH-1:0]  qk;
        logic                  qj_wait;
        logic                  qk_wait;
        logic [DATA_WIDTH-1:0] imm;
        logic [ROB_WIDTH-1:0]  rob_id;
    } rs_entry_t;

endpackage

// File: rtl/define.vh
// Shared widths, opcode encodings and boolean literals for the execution cluster.
`ifndef DEFINE_VH
`define DEFINE_VH

`define DATA_WIDTH 32
`define ROB_WIDTH  4
`define OP_WIDTH   6

`define TRUE  1'b1
`define FALSE 1'b0

`define OP_ADD  6'd1
`define OP_ADDI 6'd2
`define OP_SUB  6'd3
`define OP_AND  6'd4
`define OP_OR   6'd5
`define OP_XOR  6'd6

`endif

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: returns the index of the first set request bit.
module rs_prio_enc #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int unsigned IDX_W = $clog2(N);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes them from the ALU/LSB
// broadcast buses and issues the lowest-index ready entry to an idle ALU.
`include "define.vh"

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,

    input  logic                  dispatch_valid_in,
    input  logic [OP_WIDTH-1:0]   opcode_in,
    input  logic [DATA_WIDTH-1:0] imm_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_in,
    input  logic [DATA_WIDTH-1:0] vj_in,
    input  logic [DATA_WIDTH-1:0] vk_in,
    input  logic [ROB_WIDTH-1:0]  qj_in,
    input  logic [ROB_WIDTH-1:0]  qk_in,
    input  logic                  qj_wait_in,
    input  logic                  qk_wait_in,
    output logic                  full_out,

    input  logic                  idle_alu_in,
    output logic                  rdy_alu_out,
    output logic [OP_WIDTH-1:0]   opcode_alu_out,
    output logic [DATA_WIDTH-1:0] vj_alu_out,
    output logic [DATA_WIDTH-1:0] vk_alu_out,
    output logic [DATA_WIDTH-1:0] imm_alu_out,
    output logic [ROB_WIDTH-1:0]  rob_id_alu_out,

    input  logic                  cdb_alu_valid_in,
    input  logic [ROB_WIDTH-1:0]  cdb_alu_rob_id_in,
    input  logic [DATA_WIDTH-1:0] cdb_alu_result_in,
    input  logic                  cdb_lsb_valid_in,
    input  logic [ROB_WIDTH-1:0]  cdb_lsb_rob_id_in,
    input  logic [DATA_WIDTH-1:0] cdb_lsb_result_in
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    rs_entry_t          rs_q [RS_SIZE];
    rs_entry_t          disp_entry;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;
    logic               free_found;
    logic               ready_found;
    logic               do_dispatch;
    logic               do_issue;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = rs_q[i].busy;
            ready_vec[i] = rs_q[i].busy && !rs_q[i].qj_wait && !rs_q[i].qk_wait;
        end
    end

    rs_prio_enc #(.N(RS_SIZE)) u_free_enc (
        .req   (~busy_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_enc #(.N(RS_SIZE)) u_ready_enc (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    assign full_out    = !free_found;
    assign do_dispatch = dispatch_valid_in && !full_out;
    assign do_issue    = idle_alu_in && ready_found;

    // A waiting operand may be satisfied by a broadcast in the dispatch cycle itself.
    always_comb begin
        disp_entry         = '0;
        disp_entry.busy    = `TRUE;
        disp_entry.opcode  = opcode_in;
        disp_entry.imm     = imm_in;
        disp_entry.rob_id  = rob_id_in;
        disp_entry.qj      = qj_in;
        disp_entry.qk      = qk_in;
        disp_entry.vj      = vj_in;
        disp_entry.vk      = vk_in;
        disp_entry.qj_wait = qj_wait_in;
        disp_entry.qk_wait = qk_wait_in;
        if (qj_wait_in && cdb_alu_valid_in && cdb_alu_rob_id_in == qj_in) begin
            disp_entry.vj      = cdb_alu_result_in;
            disp_entry.qj_wait = `FALSE;
        end else if (qj_wait_in && cdb_lsb_valid_in && cdb_lsb_rob_id_in == qj_in) begin
            disp_entry.vj      = cdb_lsb_result_in;
            disp_entry.qj_wait = `FALSE;
        end
        if (qk_wait_in && cdb_alu_valid_in && cdb_alu_rob_id_in == qk_in) begin
            disp_entry.vk      = cdb_alu_result_in;
            disp_entry.qk_wait = `FALSE;
        end else if (qk_wait_in && cdb_lsb_valid_in && cdb_lsb_rob_id_in == qk_in) begin
            disp_entry.vk      = cdb_lsb_result_in;
            disp_entry.qk_wait = `FALSE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                rs_q[i] <= '0;
            end
            rdy_alu_out    <= `FALSE;
            opcode_alu_out <= '0;
            vj_alu_out     <= '0;
            vk_alu_out     <= '0;
            imm_alu_out    <= '0;
            rob_id_alu_out <= '0;
        end else if (clear_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                rs_q[i].busy <= `FALSE;
            end
            rdy_alu_out <= `FALSE;
        end else if (!rdy_in) begin
            rdy_alu_out <= `FALSE;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (rs_q[i].busy) begin
                    if (rs_q[i].qj_wait && cdb_alu_valid_in && cdb_alu_rob_id_in == rs_q[i].qj) begin
                        rs_q[i].vj      <= cdb_alu_result_in;
                        rs_q[i].qj_wait <= `FALSE;
                    end else if (rs_q[i].qj_wait && cdb_lsb_valid_in && cdb_lsb_rob_id_in == rs_q[i].qj) begin
                        rs_q[i].vj      <= cdb_lsb_result_in;
                        rs_q[i].qj_wait <= `FALSE;
                    end
                    if (rs_q[i].qk_wait && cdb_alu_valid_in && cdb_alu_rob_id_in == rs_q[i].qk) begin
                        rs_q[i].vk      <= cdb_alu_result_in;
                        rs_q[i].qk_wait <= `FALSE;
                    end else if (rs_q[i].qk_wait && cdb_lsb_valid_in && cdb_lsb_rob_id_in == rs_q[i].qk) begin
                        rs_q[i].vk      <= cdb_lsb_result_in;
                        rs_q[i].qk_wait <= `FALSE;
                    end
                end
            end

            rdy_alu_out <= do_issue;
            if (do_issue) begin
                opcode_alu_out          <= rs_q[ready_idx].opcode;
                vj_alu_out              <= rs_q[ready_idx].vj;
                vk_alu_out              <= rs_q[ready_idx].vk;
                imm_alu_out             <= rs_q[ready_idx].imm;
                rob_id_alu_out          <= rs_q[ready_idx].rob_id;
                rs_q[ready_idx].busy    <= `FALSE;
            end

            // Free slot comes from pre-edge busy bits, so a slot issued this cycle is not reused yet.
            if (do_dispatch) begin
                rs_q[free_idx] <= disp_entry;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs with a per-cycle behavioural model and literal spot checks.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        dispatch_valid_in;
    logic [5:0]  opcode_in;
    logic [31:0] imm_in, vj_in, vk_in;
    logic [3:0]  rob_id_in, qj_in, qk_in;
    logic        qj_wait_in, qk_wait_in;
    logic        full_out;
    logic        idle_alu_in;
    logic        rdy_alu_out;
    logic [5:0]  opcode_alu_out;
    logic [31:0] vj_alu_out, vk_alu_out, imm_alu_out;
    logic [3:0]  rob_id_alu_out;
    logic        cdb_alu_valid_in, cdb_lsb_valid_in;
    logic [3:0]  cdb_alu_rob_id_in, cdb_lsb_rob_id_in;
    logic [31:0] cdb_alu_result_in, cdb_lsb_result_in;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    alu_rs #(.RS_SIZE(N)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .dispatch_valid_in(dispatch_valid_in), .opcode_in(opcode_in), .imm_in(imm_in),
        .rob_id_in(rob_id_in), .vj_in(vj_in), .vk_in(vk_in), .qj_in(qj_in), .qk_in(qk_in),
        .qj_wait_in(qj_wait_in), .qk_wait_in(qk_wait_in), .full_out(full_out),
        .idle_alu_in(idle_alu_in), .rdy_alu_out(rdy_alu_out), .opcode_alu_out(opcode_alu_out),
        .vj_alu_out(vj_alu_out), .vk_alu_out(vk_alu_out), .imm_alu_out(imm_alu_out),
        .rob_id_alu_out(rob_id_alu_out),
        .cdb_alu_valid_in(cdb_alu_valid_in), .cdb_alu_rob_id_in(cdb_alu_rob_id_in),
        .cdb_alu_result_in(cdb_alu_result_in),
        .cdb_lsb_valid_in(cdb_lsb_valid_in), .cdb_lsb_rob_id_in(cdb_lsb_rob_id_in),
        .cdb_lsb_result_in(cdb_lsb_result_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the station as a table of pending ops
    bit          m_busy [N];
    logic [5:0]  m_op   [N];
    logic [31:0] m_vj [N], m_vk [N], m_imm [N];
    logic [3:0]  m_qj [N], m_qk [N], m_rob [N];
    bit          m_wj [N], m_wk [N];
    bit          m_rdy;
    logic [5:0]  m_o_op;
    logic [31:0] m_o_vj, m_o_vk, m_o_imm;
    logic [3:0]  m_o_rob;

    function automatic bit m_full();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit hit(input bit v, input logic [3:0] id, input logic [3:0] tag);
        return v && id == tag;
    endfunction

    always @(posedge clk) begin : model
        int ri, fi;
        if (!rst_in) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0; m_wj[i] = 0; m_wk[i] = 0;
            end
            m_rdy = 0; m_o_op = 0; m_o_vj = 0; m_o_vk = 0; m_o_imm = 0; m_o_rob = 0;
        end else if (clear_in) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            m_rdy = 0;
        end else if (!rdy_in) begin
            m_rdy = 0;
        end else begin
            ri = -1; fi = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (m_busy[i] && !m_wj[i] && !m_wk[i]) ri = i;
                if (!m_busy[i]) fi = i;
            end
            for (int i = 0; i < N; i++) if (m_busy[i]) begin
                if (m_wj[i] && hit(cdb_alu_valid_in, cdb_alu_rob_id_in, m_qj[i])) begin m_vj[i] = cdb_alu_result_in; m_wj[i] = 0; end
                else if (m_wj[i] && hit(cdb_lsb_valid_in, cdb_lsb_rob_id_in, m_qj[i])) begin m_vj[i] = cdb_lsb_result_in; m_wj[i] = 0; end
                if (m_wk[i] && hit(cdb_alu_valid_in, cdb_alu_rob_id_in, m_qk[i])) begin m_vk[i] = cdb_alu_result_in; m_wk[i] = 0; end
                else if (m_wk[i] && hit(cdb_lsb_valid_in, cdb_lsb_rob_id_in, m_qk[i])) begin m_vk[i] = cdb_lsb_result_in; m_wk[i] = 0; end
            end
            m_rdy = idle_alu_in && ri >= 0;
            if (m_rdy) begin
                m_o_op = m_op[ri]; m_o_vj = m_vj[ri]; m_o_vk = m_vk[ri];
                m_o_imm = m_imm[ri]; m_o_rob = m_rob[ri]; m_busy[ri] = 0;
            end
            if (dispatch_valid_in && fi >= 0) begin
                m_busy[fi] = 1; m_op[fi] = opcode_in; m_imm[fi] = imm_in; m_rob[fi] = rob_id_in;
                m_qj[fi] = qj_in; m_qk[fi] = qk_in;
                m_vj[fi] = vj_in; m_wj[fi] = qj_wait_in;
                m_vk[fi] = vk_in; m_wk[fi] = qk_wait_in;
                if (qj_wait_in && hit(cdb_alu_valid_in, cdb_alu_rob_id_in, qj_in)) begin m_vj[fi] = cdb_alu_result_in; m_wj[fi] = 0; end
                else if (qj_wait_in && hit(cdb_lsb_valid_in, cdb_lsb_rob_id_in, qj_in)) begin m_vj[fi] = cdb_lsb_result_in; m_wj[fi] = 0; end
                if (qk_wait_in && hit(cdb_alu_valid_in, cdb_alu_rob_id_in, qk_in)) begin m_vk[fi] = cdb_alu_result_in; m_wk[fi] = 0; end
                else if (qk_wait_in && hit(cdb_lsb_valid_in, cdb_lsb_rob_id_in, qk_in)) begin m_vk[fi] = cdb_lsb_result_in; m_wk[fi] = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_rdy", {31'd0, rdy_alu_out}, {31'd0, m_rdy});
            chk("model_full", {31'd0, full_out}, {31'd0, m_full()});
            chk("model_op", {26'd0, opcode_alu_out}, {26'd0, m_o_op});
            chk("model_vj", vj_alu_out, m_o_vj);
            chk("model_vk", vk_alu_out, m_o_vk);
            chk("model_imm", imm_alu_out, m_o_imm);
            chk("model_rob", {28'd0, rob_id_alu_out}, {28'd0, m_o_rob});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] imm, input logic [3:0] rob,
                        input logic [3:0] qj, input bit wj, input logic [3:0] qk, input bit wk);
        dispatch_valid_in = 1; opcode_in = op; vj_in = vj; vk_in = vk; imm_in = imm;
        rob_id_in = rob; qj_in = qj; qj_wait_in = wj; qk_in = qk; qk_wait_in = wk;
        step();
        dispatch_valid_in = 0; qj_wait_in = 0; qk_wait_in = 0;
    endtask

    initial begin
        rst_in = 0; rdy_in = 1; clear_in = 0; idle_alu_in = 1;
        dispatch_valid_in = 0; opcode_in = 0; imm_in = 0; vj_in = 0; vk_in = 0;
        rob_id_in = 0; qj_in = 0; qk_in = 0; qj_wait_in = 0; qk_wait_in = 0;
        cdb_alu_valid_in = 0; cdb_alu_rob_id_in = 0; cdb_alu_result_in = 0;
        cdb_lsb_valid_in = 0; cdb_lsb_rob_id_in = 0; cdb_lsb_result_in = 0;

        repeat (2) step();
        rst_in = 1;
        started = 1;
        chk("reset_rdy", {31'd0, rdy_alu_out}, 32'd0);
        chk("reset_full", {31'd0, full_out}, 32'd0);
        chk("reset_vj", vj_alu_out, 32'd0);

        // Basic ADD, two-edge latency
        disp(OP_ADD, 32'd5, 32'd7, 32'd0, 4'd1, 4'd0, 0, 4'd0, 0);
        chk("add_not_yet", {31'd0, rdy_alu_out}, 32'd0);
        step();
        chk("add_rdy", {31'd0, rdy_alu_out}, 32'd1);
        chk("add_op", {26'd0, opcode_alu_out}, 32'd1);
        chk("add_vj", vj_alu_out, 32'd5);
        chk("add_vk", vk_alu_out, 32'd7);
        step();
        chk("add_single_pulse", {31'd0, rdy_alu_out}, 32'd0);

        // ADDI waiting on tag 3, woken by ALU broadcast
        disp(OP_ADDI, 32'd0, 32'd0, 32'd4, 4'd2, 4'd3, 1, 4'd0, 0);
        step();
        chk("addi_wait", {31'd0, rdy_alu_out}, 32'd0);
        cdb_alu_valid_in = 1; cdb_alu_rob_id_in = 4'd3; cdb_alu_result_in = 32'h10;
        step();
        cdb_alu_valid_in = 0;
        chk("addi_wake_edge", {31'd0, rdy_alu_out}, 32'd0);
        step();
        chk("addi_rdy", {31'd0, rdy_alu_out}, 32'd1);
        chk("addi_vj", vj_alu_out, 32'h10);
        chk("addi_imm", imm_alu_out, 32'd4);

        // Fill all entries waiting on tag 9, drop a ninth, release via LSB
        for (int i = 0; i < N; i++)
            disp(OP_ADD, 32'd0, 32'd1, 32'd0, 4'(i), 4'd9, 1, 4'd0, 0);
        chk("fill_full", {31'd0, full_out}, 32'd1);
        disp(OP_ADD, 32'd1, 32'd1, 32'd0, 4'd15, 4'd0, 0, 4'd0, 0);
        chk("drop_full", {31'd0, full_out}, 32'd1);
        chk("drop_rdy", {31'd0, rdy_alu_out}, 32'd0);
        cdb_lsb_valid_in = 1; cdb_lsb_rob_id_in = 4'd9; cdb_lsb_result_in = 32'h99;
        step();
        cdb_lsb_valid_in = 0;
        chk("fill_wake_edge", {31'd0, rdy_alu_out}, 32'd0);
        for (int i = 0; i < N; i++) begin
            step();
            chk("fill_issue_rdy", {31'd0, rdy_alu_out}, 32'd1);
            chk("fill_issue_rob", {28'd0, rob_id_alu_out}, 32'(i));
            chk("fill_issue_vj", vj_alu_out, 32'h99);
            if (i == 0) chk("fill_full_drop", {31'd0, full_out}, 32'd0);
        end
        step();
        chk("fill_drained", {31'd0, rdy_alu_out}, 32'd0);

        // Same-cycle dispatch capture
        cdb_alu_valid_in = 1; cdb_alu_rob_id_in = 4'd2; cdb_alu_result_in = 32'hAB;
        disp(OP_ADDI, 32'd0, 32'd0, 32'd0, 4'd6, 4'd2, 1, 4'd0, 0);
        cdb_alu_valid_in = 0;
        chk("cap_edge", {31'd0, rdy_alu_out}, 32'd0);
        step();
        chk("cap_rdy", {31'd0, rdy_alu_out}, 32'd1);
        chk("cap_vj", vj_alu_out, 32'hAB);
        chk("cap_rob", {28'd0, rob_id_alu_out}, 32'd6);

        // Flush four held entries
        idle_alu_in = 0;
        for (int i = 1; i <= 4; i++)
            disp(OP_ADD, 32'(i), 32'd0, 32'd0, 4'(i), 4'd0, 0, 4'd0, 0);
        clear_in = 1;
        step();
        clear_in = 0; idle_alu_in = 1;
        repeat (3) begin
            step();
            chk("clear_no_pulse", {31'd0, rdy_alu_out}, 32'd0);
            chk("clear_full", {31'd0, full_out}, 32'd0);
        end
        disp(OP_ADD, 32'h55, 32'd0, 32'd0, 4'd5, 4'd0, 0, 4'd0, 0);
        step();
        chk("post_clear_rdy", {31'd0, rdy_alu_out}, 32'd1);
        chk("post_clear_rob", {28'd0, rob_id_alu_out}, 32'd5);
        chk("post_clear_vj", vj_alu_out, 32'h55);

        // ALU busy holds ready entries; lower index goes first
        idle_alu_in = 0;
        disp(OP_ADD, 32'hA, 32'd0, 32'd0, 4'd10, 4'd0, 0, 4'd0, 0);
        disp(OP_ADD, 32'hB, 32'd0, 32'd0, 4'd11, 4'd0, 0, 4'd0, 0);
        repeat (5) begin
            step();
            chk("stall_no_issue", {31'd0, rdy_alu_out}, 32'd0);
        end
        idle_alu_in = 1;
        step();
        chk("stall_first_rob", {28'd0, rob_id_alu_out}, 32'd10);
        step();
        chk("stall_second_rob", {28'd0, rob_id_alu_out}, 32'd11);
        step();
        chk("stall_done", {31'd0, rdy_alu_out}, 32'd0);

        // Global enable low: dispatch ignored
        rdy_in = 0;
        disp(OP_ADD, 32'd1, 32'd2, 32'd0, 4'd12, 4'd0, 0, 4'd0, 0);
        chk("hold_rdy", {31'd0, rdy_alu_out}, 32'd0);
        rdy_in = 1;
        repeat (2) begin
            step();
            chk("hold_nothing_stored", {31'd0, rdy_alu_out}, 32'd0);
        end

        // Reset discards an in-flight dispatch
        rst_in = 0;
        disp(OP_ADD, 32'd3, 32'd4, 32'd0, 4'd13, 4'd0, 0, 4'd0, 0);
        rst_in = 1;
        chk("rst_vj_zero", vj_alu_out, 32'd0);
        step();
        chk("rst_discard", {31'd0, rdy_alu_out}, 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
